// File: rtl/bp_stream_pkg.sv
// Shared types for the NBF stream UART receiver: receive FSM states and UART framing constants.
// BP_STREAM_UART_PARITY_EN adds the e_parity state.
package bp_stream_pkg;

    localparam int uart_data_bits_gp = 8;

    typedef enum logic [2:0] {
        e_idle,
        e_start,
        e_data,
`ifdef BP_STREAM_UART_PARITY_EN
        e_parity,
`endif
        e_stop,
        e_wait_high
    } rx_state_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, baud counter and framing FSM (8N1, or 8E1 when
// BP_STREAM_UART_PARITY_EN is defined).
module bp_uart_rx_byte
    import bp_stream_pkg::*;
#(
    parameter int clk_per_bit_p = 868
)
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         rx_i,
    output logic                         byte_v_o,
    output logic [uart_data_bits_gp-1:0] byte_data_o,
    output logic                         framing_error_o
`ifdef BP_STREAM_UART_PARITY_EN
    ,
    output logic                         parity_error_o
`endif
);

    localparam int cnt_width_lp     = safe_clog2(clk_per_bit_p);
    localparam int bit_idx_width_lp = safe_clog2(uart_data_bits_gp);
    localparam logic [cnt_width_lp-1:0]     half_last_lp = cnt_width_lp'(clk_per_bit_p/2 - 1);
    localparam logic [cnt_width_lp-1:0]     bit_last_lp  = cnt_width_lp'(clk_per_bit_p - 1);
    localparam logic [bit_idx_width_lp-1:0] data_last_lp = bit_idx_width_lp'(uart_data_bits_gp - 1);

    logic [1:0]                   sync_q, sync_d;
    rx_state_e                    state_q, state_d;
    logic [cnt_width_lp-1:0]      cnt_q, cnt_d;
    logic [bit_idx_width_lp-1:0]  bit_idx_q, bit_idx_d;
    logic [uart_data_bits_gp-1:0] shift_q, shift_d;
    logic                         rx_s, bit_end, stop_sample;
`ifdef BP_STREAM_UART_PARITY_EN
    logic                         parity_ok_q, parity_ok_d;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d    = {sync_q[0], rx_i};
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        bit_end   = (cnt_q == bit_last_lp);
`ifdef BP_STREAM_UART_PARITY_EN
        parity_ok_d = parity_ok_q;
`endif
        unique case (state_q)
            e_idle: begin
                cnt_d = '0;
                if (!rx_s) state_d = e_start;
            end
            // Half-bit wait re-centres every later sample on mid-bit.
            e_start: begin
                if (cnt_q == half_last_lp) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? e_idle : e_data;
                end
            end
            e_data: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[uart_data_bits_gp-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == data_last_lp) begin
`ifdef BP_STREAM_UART_PARITY_EN
                        state_d = e_parity;
`else
                        state_d = e_stop;
`endif
                    end
                end
            end
`ifdef BP_STREAM_UART_PARITY_EN
            e_parity: begin
                if (bit_end) begin
                    cnt_d       = '0;
                    parity_ok_d = ~^{shift_q, rx_s};
                    state_d     = e_stop;
                end
            end
`endif
            e_stop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = rx_s ? e_idle : e_wait_high;
                end
            end
            e_wait_high: begin
                cnt_d = '0;
                if (rx_s) state_d = e_idle;
            end
            default: begin
                cnt_d   = '0;
                state_d = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q    <= 2'b11;
            state_q   <= e_idle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
`ifdef BP_STREAM_UART_PARITY_EN
            parity_ok_q <= 1'b1;
`endif
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
`ifdef BP_STREAM_UART_PARITY_EN
            parity_ok_q <= parity_ok_d;
`endif
        end
        shift_q <= shift_d;
    end

    // Pulses are decoded from registered state so the packed word is valid the cycle after the stop sample.
    assign stop_sample     = (state_q == e_stop) && bit_end;
    assign byte_data_o     = shift_q;
    assign framing_error_o = stop_sample & ~rx_s;
`ifdef BP_STREAM_UART_PARITY_EN
    assign byte_v_o        = stop_sample & rx_s & parity_ok_q;
    assign parity_error_o  = stop_sample & rx_s & ~parity_ok_q;
`else
    assign byte_v_o        = stop_sample & rx_s;
`endif

endmodule

// File: rtl/bp_stream_uart_rx.sv
// UART receiver feeding the NBF loader: packs received bytes little-endian into words and buffers them.
// BP_STREAM_UART_PARITY_EN enables even-parity checking and the parity_error_o port.
module bp_stream_uart_rx
    import bp_stream_pkg::*;
#(
    parameter int clk_per_bit_p       = 868,
    parameter int stream_data_width_p = 32,
    parameter int out_els_p           = 2
)
(
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           rx_i,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic                           framing_error_o,
`ifdef BP_STREAM_UART_PARITY_EN
    output logic                           parity_error_o,
`endif
    output logic                           overflow_o
);

    localparam int lanes_lp     = stream_data_width_p / uart_data_bits_gp;
    localparam int idx_width_lp = safe_clog2(lanes_lp);
    localparam int ptr_width_lp = safe_clog2(out_els_p);
    localparam int cnt_width_lp = $clog2(out_els_p + 1);
    localparam logic [idx_width_lp-1:0] idx_last_lp = idx_width_lp'(lanes_lp - 1);
    localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(out_els_p - 1);
    localparam logic [cnt_width_lp-1:0] els_lp      = cnt_width_lp'(out_els_p);

    logic                           byte_v;
    logic [uart_data_bits_gp-1:0]   byte_data;
    logic [idx_width_lp-1:0]        idx_q, idx_d;
    logic [stream_data_width_p-1:0] word_q, word_d, lane_word;
    logic [stream_data_width_p-1:0] mem_q [out_els_p];
    logic [stream_data_width_p-1:0] mem_d [out_els_p];
    logic [ptr_width_lp-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_width_lp-1:0]        count_q, count_d;
    logic                           overflow_q, overflow_d;
    logic                           full, deq, last_byte, enq, drop;

    bp_uart_rx_byte #(.clk_per_bit_p(clk_per_bit_p)) u_byte (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .rx_i            (rx_i),
        .byte_v_o        (byte_v),
        .byte_data_o     (byte_data),
`ifdef BP_STREAM_UART_PARITY_EN
        .parity_error_o  (parity_error_o),
`endif
        .framing_error_o (framing_error_o)
    );

    assign stream_v_o    = (count_q != '0);
    assign stream_data_o = mem_q[rptr_q];
    assign overflow_o    = overflow_q;

    // A full buffer still accepts the word when the loader drains one the same cycle.
    assign full      = (count_q == els_lp);
    assign deq       = stream_v_o & stream_ready_i;
    assign last_byte = byte_v && (idx_q == idx_last_lp);
    assign enq       = last_byte && (!full || deq);
    assign drop      = last_byte && !enq;

    always_comb begin
        lane_word = word_q;
        for (int i = 0; i < lanes_lp; i++) begin
            if (idx_q == idx_width_lp'(i))
                lane_word[i*uart_data_bits_gp +: uart_data_bits_gp] = byte_data;
        end

        word_d     = (byte_v && !drop) ? lane_word : word_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | drop;
        if (enq)
            idx_d = '0;
        else if (byte_v && !last_byte)
            idx_d = idx_q + 1'b1;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (enq) begin
            mem_d[wptr_q] = lane_word;
            wptr_d = (wptr_q == ptr_last_lp) ? '0 : wptr_q + 1'b1;
        end
        if (deq)
            rptr_d = (rptr_q == ptr_last_lp) ? '0 : rptr_q + 1'b1;

        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q      <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
        word_q <= word_d;
        mem_q  <= mem_d;
    end

endmodule

// File: tb/tb_bp_stream_uart_rx.sv
// Randomized bench for bp_stream_uart_rx against a byte/word queue model of the packer and buffer.
module tb_bp_stream_uart_rx;

    localparam int cpb_lp   = 8;
    localparam int width_lp = 32;
    localparam int els_lp   = 2;
    localparam int lanes_lp = width_lp / 8;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                rx_i = 1'b1;
    logic                stream_ready_i = 1'b1;
    logic                stream_v_o, framing_error_o, overflow_o;
    logic [width_lp-1:0] stream_data_o;
`ifdef BP_STREAM_UART_PARITY_EN
    logic                parity_error_o;
    int                  pe_cnt = 0;
`endif

    int                  checks = 0, errors = 0;
    int                  fe_cnt = 0, v_cycles = 0;
    logic [width_lp-1:0] exp_q[$];
    logic [7:0]          pend_q[$];
    logic                exp_ovf = 1'b0;
    logic [width_lp-1:0] last_word = '0;

    always #5 clk_i = ~clk_i;

    bp_stream_uart_rx #(
        .clk_per_bit_p       (cpb_lp),
        .stream_data_width_p (width_lp),
        .out_els_p           (els_lp)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .rx_i            (rx_i),
        .stream_v_o      (stream_v_o),
        .stream_data_o   (stream_data_o),
        .stream_ready_i  (stream_ready_i),
        .framing_error_o (framing_error_o),
`ifdef BP_STREAM_UART_PARITY_EN
        .parity_error_o  (parity_error_o),
`endif
        .overflow_o      (overflow_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: bytes collect until a word's worth; a word enters the buffer if there is room, else the byte is lost.
    function automatic void model_byte(input logic [7:0] b);
        logic [width_lp-1:0] w;
        pend_q.push_back(b);
        if (pend_q.size() == lanes_lp) begin
            if (exp_q.size() < els_lp) begin
                w = '0;
                for (int i = 0; i < lanes_lp; i++) w |= width_lp'(pend_q[i]) << (8 * i);
                exp_q.push_back(w);
                pend_q.delete();
            end else begin
                void'(pend_q.pop_back());
                exp_ovf = 1'b1;
            end
        end
    endfunction

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (framing_error_o) fe_cnt++;
`ifdef BP_STREAM_UART_PARITY_EN
            if (parity_error_o) pe_cnt++;
`endif
            if (stream_v_o) begin
                v_cycles++;
                if (exp_q.size() == 0) begin
                    check_eq("word_expected", exp_q.size(), 1);
                end else if (stream_ready_i) begin
                    last_word = stream_data_o;
                    check_eq("word", stream_data_o, exp_q.pop_front());
                end else begin
                    check_eq("word_held", stream_data_o, exp_q[0]);
                end
            end
        end
    end

    task automatic bit_time(input logic v);
        rx_i = v;
        repeat (cpb_lp) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef BP_STREAM_UART_PARITY_EN
        bit_time((^b) ^ par_flip);
`endif
        if (stop_bit && !par_flip) model_byte(b);
        bit_time(stop_bit);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40 * cpb_lp) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        rx_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        exp_q.delete();
        pend_q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, fe0;
        logic [7:0] b1, b2, b3, b13;

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_v", stream_v_o, 0);
        check_eq("rst_fe", framing_error_o, 0);
        check_eq("rst_ovf", overflow_o, 0);
        reset_i = 1'b0;
        repeat (2 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("idle_v", stream_v_o, 0);

        v0 = v_cycles;
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        wait_drain("basic_drain");
        check_eq("basic_word", last_word, 32'h1234_5678);
        check_eq("basic_vcycles", v_cycles - v0, 1);

        fe0 = fe_cnt;
        rx_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        repeat (4 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("glitch_fe", fe_cnt - fe0, 0);
        check_eq("glitch_v", stream_v_o, 0);
        send_byte(8'hA5);

        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (40) @(posedge clk_i);
        #1;
        check_eq("break_fe", fe_cnt - fe0, 1);
        rx_i = 1'b1;
        repeat (2 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("break_fe_once", fe_cnt - fe0, 1);
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        send_byte(b1); send_byte(b2); send_byte(b3);
        wait_drain("glitch_drain");
        check_eq("glitch_word", last_word, {b3, b2, b1, 8'hA5});

        for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 20)) @(posedge clk_i);
            #1;
        end
        wait_drain("rand_drain");
        check_eq("rand_ovf", overflow_o, 0);

        stream_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) send_byte(8'($urandom));
        repeat (2 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("stall_v", stream_v_o, 1);
        check_eq("stall_depth", exp_q.size(), els_lp);
        check_eq("ovf_set", overflow_o, 1);
        check_eq("ovf_model", overflow_o, exp_ovf);
        stream_ready_i = 1'b1;
        wait_drain("stall_drain");
        b13 = 8'($urandom);
        send_byte(b13);
        wait_drain("retry_drain");
        check_eq("retry_lane", last_word[31:24], b13);
        check_eq("ovf_sticky", overflow_o, 1);

        send_byte(8'($urandom)); send_byte(8'($urandom));
        bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
        do_reset();
        repeat (2 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("midrst_ovf", overflow_o, 0);
        check_eq("midrst_v", stream_v_o, 0);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        wait_drain("midrst_drain");
        check_eq("midrst_word", last_word, 32'h0102_0304);

`ifdef BP_STREAM_UART_PARITY_EN
        fe0 = pe_cnt;
        send_frame(8'h03, 1'b1, 1'b1);
        repeat (2 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("par_err", pe_cnt - fe0, 1);
        check_eq("par_v", stream_v_o, 0);
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_drain("par_drain");
        check_eq("par_word", last_word, 32'h3322_1103);
`endif

        repeat (2 * cpb_lp) @(posedge clk_i);
        #1;
        check_eq("final_ovf", overflow_o, exp_ovf);
        check_eq("final_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
